// File: rtl/wb_pkg.sv
// wb_pkg: load funct3 encodings, source ids and stage entry layout shared by the writeback stage
package wb_pkg;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;
  localparam int WB_SRC_MEM = 0;
  localparam int WB_XLEN = 32;
  localparam int WB_RADDR_W = 5;
  // Field order of the stage register; wb_stage builds the same layout at its own widths
  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [WB_RADDR_W-1:0] rd;
    logic [WB_XLEN-1:0]    data;
    logic                  misalign;
  } wb_entry_t;
endpackage

// File: rtl/wb_stage_ld_align.sv
// ld_align: combinational load byte alignment, zero/sign extension and misalignment detect
module ld_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] src,
  input  logic [2:0]      funct3,
  input  logic [2:0]      addr_lo,
  output logic [XLEN-1:0] data,
  output logic            misalign
);
  logic [XLEN-1:0] sh, w_s, w_z;
  assign sh = src >> {addr_lo, 3'b000};
  // Word extraction only exists on 64-bit datapaths; otherwise the shifted word passes through
  generate
    if (XLEN >= 64) begin : g_w
      assign w_s = {{(XLEN-32){sh[31]}}, sh[31:0]};
      assign w_z = {{(XLEN-32){1'b0}}, sh[31:0]};
    end else begin : g_n
      assign w_s = sh;
      assign w_z = sh;
    end
  endgenerate
  always_comb begin
    data = funct3 == LB  ? {{(XLEN-8){sh[7]}}, sh[7:0]} :
           funct3 == LBU ? {{(XLEN-8){1'b0}}, sh[7:0]} :
           funct3 == LH  ? {{(XLEN-16){sh[15]}}, sh[15:0]} :
           funct3 == LHU ? {{(XLEN-16){1'b0}}, sh[15:0]} :
           funct3 == LW  ? w_s :
           funct3 == LWU ? w_z : sh;
    misalign = (funct3 == LH || funct3 == LHU) ? addr_lo[0] :
               (funct3 == LW || funct3 == LWU) ? |addr_lo[1:0] :
               funct3 == LD ? |addr_lo : 1'b0;
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register with N-source writeback select; WB_STAGE_RETIRE_CNT_EN adds retire_cnt
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 4,
  parameter int RADDR_W = 5,
  localparam int SEL_W  = $clog2(NUM_SRC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_SRC*XLEN-1:0] in_src,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_we,
  input  logic [RADDR_W-1:0]      in_rd,
  input  logic [2:0]              in_ld_funct3,
  input  logic [2:0]              in_addr_lo,
  input  logic                    stall,
  input  logic                    flush,
  output logic                    rf_we,
  output logic [RADDR_W-1:0]      rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic                    fwd_valid,
  output logic [RADDR_W-1:0]      fwd_rd,
  output logic [XLEN-1:0]         fwd_data,
`ifdef WB_STAGE_RETIRE_CNT_EN
  output logic [63:0]             retire_cnt,
`endif
  output logic                    ld_misalign
);
  typedef struct packed {
    logic               valid;
    logic               we;
    logic [RADDR_W-1:0] rd;
    logic [XLEN-1:0]    data;
    logic               misalign;
  } entry_t;
  entry_t e_q, e_d, e_in;
  logic [XLEN-1:0] mux_data, ld_data;
  logic ld_mis, is_ld, xfer, wr_ok;
  ld_align #(.XLEN(XLEN)) u_ld_align (
    .src(in_src[XLEN-1:0]),
    .funct3(in_ld_funct3),
    .addr_lo(in_addr_lo),
    .data(ld_data),
    .misalign(ld_mis)
  );
  always_comb begin
    mux_data = '0;
    for (int k = 1; k < NUM_SRC; k++)
      if (32'(in_sel) == k) mux_data = in_src[k*XLEN +: XLEN];
  end
  assign in_ready = !stall && !rst;
  assign xfer = in_valid && in_ready;
  assign is_ld = 32'(in_sel) == WB_SRC_MEM;
  always_comb begin
    e_in.valid = 1'b1;
    e_in.we = in_we;
    e_in.rd = in_rd;
    e_in.data = is_ld ? ld_data : mux_data;
    e_in.misalign = is_ld && in_we && ld_mis;
    e_d = flush ? '0 : stall ? e_q : xfer ? e_in : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) e_q <= '0;
    else e_q <= e_d;
  end
  assign wr_ok = e_q.valid && e_q.we && e_q.rd != '0 && !e_q.misalign;
  assign rf_we = wr_ok && !stall;
  assign rf_waddr = rf_we ? e_q.rd : '0;
  assign rf_wdata = rf_we ? e_q.data : '0;
  assign fwd_valid = wr_ok;
  assign fwd_rd = wr_ok ? e_q.rd : '0;
  assign fwd_data = wr_ok ? e_q.data : '0;
  assign ld_misalign = e_q.valid && e_q.misalign && !stall;
`ifdef WB_STAGE_RETIRE_CNT_EN
  logic [63:0] cnt_q, cnt_d;
  assign cnt_d = cnt_q + 64'(e_q.valid && !stall);
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign retire_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table vectors, hand sequences and randomized traffic against a scoreboard model
module tb_wb_stage;
  localparam int XLEN = 32;
  localparam int NUM_SRC = 4;
  localparam int RADDR_W = 5;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, in_valid, in_ready, in_we, stall, flush;
  logic [NUM_SRC*XLEN-1:0] in_src;
  logic [1:0] in_sel;
  logic [RADDR_W-1:0] in_rd, rf_waddr, fwd_rd;
  logic [2:0] in_ld_funct3, in_addr_lo;
  logic rf_we, fwd_valid, ld_misalign;
  logic [XLEN-1:0] rf_wdata, fwd_data;
`ifdef WB_STAGE_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif
  wb_stage #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .RADDR_W(RADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_src(in_src), .in_sel(in_sel), .in_we(in_we), .in_rd(in_rd),
    .in_ld_funct3(in_ld_funct3), .in_addr_lo(in_addr_lo),
    .stall(stall), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`ifdef WB_STAGE_RETIRE_CNT_EN
    .retire_cnt(retire_cnt),
`endif
    .ld_misalign(ld_misalign)
  );

  int total = 0;
  int bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: the one instruction expected to sit in writeback
  bit m_v, m_we, m_mis;
  logic [RADDR_W-1:0] m_rd;
  logic [XLEN-1:0] m_dat;
  longint unsigned m_cnt;

  function automatic logic [XLEN-1:0] ref_ld(input logic [XLEN-1:0] s, input logic [2:0] f3, input logic [2:0] a);
    int sz = 1 << f3[1:0];
    logic [63:0] v = 64'(s) >> (8 * a);
    logic [63:0] m;
    if (8 * sz < XLEN) begin
      m = (64'd1 << (8 * sz)) - 64'd1;
      v = v & m;
      if (!f3[2] && v[8*sz-1]) v = v | ~m;
    end
    return v[XLEN-1:0];
  endfunction

  function automatic bit ref_mis(input logic [2:0] f3, input logic [2:0] a);
    int sz = 1 << f3[1:0];
    return f3 != 3'b111 && sz > 1 && (int'(a) % sz) != 0;
  endfunction

  task automatic cycle();
    bit ew, fv, n_v, n_we, n_mis;
    logic [RADDR_W-1:0] n_rd;
    logic [XLEN-1:0] n_dat;
    longint unsigned n_cnt;
    #1;
    fv = m_v && m_we && m_rd != 0 && !m_mis;
    ew = fv && !stall;
    chk("in_ready", in_ready, !stall && !rst);
    chk("rf_we", rf_we, ew);
    chk("rf_waddr", rf_waddr, ew ? m_rd : 0);
    chk("rf_wdata", rf_wdata, ew ? m_dat : 0);
    chk("fwd_valid", fwd_valid, fv);
    chk("fwd_rd", fwd_rd, fv ? m_rd : 0);
    chk("fwd_data", fwd_data, fv ? m_dat : 0);
    chk("ld_misalign", ld_misalign, m_v && m_mis && !stall);
`ifdef WB_STAGE_RETIRE_CNT_EN
    chk("retire_cnt", retire_cnt, m_cnt);
`endif
    {n_v, n_we, n_mis, n_rd, n_dat} = {m_v, m_we, m_mis, m_rd, m_dat};
    n_cnt = m_cnt + ((m_v && !stall) ? 1 : 0);
    if (rst) begin
      n_v = 0;
      n_cnt = 0;
    end else if (flush) n_v = 0;
    else if (!stall) begin
      n_v = in_valid;
      n_we = in_we;
      n_rd = in_rd;
      n_dat = in_sel == 0 ? ref_ld(in_src[XLEN-1:0], in_ld_funct3, in_addr_lo) : in_src[int'(in_sel)*XLEN +: XLEN];
      n_mis = in_sel == 0 && in_we && ref_mis(in_ld_funct3, in_addr_lo);
    end
    @(posedge clk);
    #1;
    {m_v, m_we, m_mis, m_rd, m_dat} = {n_v, n_we, n_mis, n_rd, n_dat};
    m_cnt = n_cnt;
  endtask

  task automatic drive(input bit v, input logic [1:0] sel, input logic [2:0] f3, input logic [2:0] a,
                       input bit we, input logic [4:0] rd, input logic [31:0] s0, input logic [31:0] sk,
                       input bit st, input bit fl);
    in_valid = v; in_sel = sel; in_ld_funct3 = f3; in_addr_lo = a; in_we = we; in_rd = rd;
    in_src = {32'h3333_3333, sk, 32'h1111_1111, s0};
    stall = st; flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [2:0]  a;
    logic [31:0] s0;
    logic [31:0] sk;
    logic [4:0]  rd;
    bit          ewe;
    logic [31:0] edat;
    bit          emis;
  } vec_t;
  vec_t tv[16];
  longint unsigned c0;

  initial begin
    tv[0]  = '{0, 3'b000, 3, 32'h8012_3456, 0, 3, 1, 32'hFFFF_FF80, 0};
    tv[1]  = '{0, 3'b100, 3, 32'h8012_3456, 0, 3, 1, 32'h0000_0080, 0};
    tv[2]  = '{0, 3'b001, 2, 32'h8012_3456, 0, 3, 1, 32'hFFFF_8012, 0};
    tv[3]  = '{0, 3'b101, 2, 32'h8012_3456, 0, 3, 1, 32'h0000_8012, 0};
    tv[4]  = '{0, 3'b010, 0, 32'h8012_3456, 0, 3, 1, 32'h8012_3456, 0};
    tv[5]  = '{0, 3'b101, 1, 32'h8012_3456, 0, 5, 0, 32'h0, 1};
    tv[6]  = '{0, 3'b000, 1, 32'h8012_3456, 0, 3, 1, 32'h0000_0034, 0};
    tv[7]  = '{0, 3'b010, 2, 32'h8012_3456, 0, 3, 0, 32'h0, 1};
    tv[8]  = '{0, 3'b001, 0, 32'h0000_7FFF, 0, 3, 1, 32'h0000_7FFF, 0};
    tv[9]  = '{2, 3'b101, 1, 32'h8012_3456, 32'hCAFE_F00D, 3, 1, 32'hCAFE_F00D, 0};
    tv[10] = '{2, 3'b000, 0, 32'h0, 32'h1234_5678, 0, 0, 32'h0, 0};
    tv[11] = '{0, 3'b011, 0, 32'h8012_3456, 0, 3, 1, 32'h8012_3456, 0};
    tv[12] = '{0, 3'b011, 4, 32'h8012_3456, 0, 3, 0, 32'h0, 1};
    tv[13] = '{0, 3'b000, 4, 32'h8012_3456, 0, 3, 1, 32'h0, 0};
    tv[14] = '{0, 3'b110, 0, 32'h8012_3456, 0, 3, 1, 32'h8012_3456, 0};
    tv[15] = '{0, 3'b000, 2, 32'h8012_3456, 0, 3, 1, 32'h0000_0012, 0};
    {m_v, m_we, m_mis, m_rd, m_dat} = '0;
    m_cnt = 0;
    rst = 1;
    idle();
    cycle();
    cycle();
    rst = 0;
    #1;
    chk("post_reset_ready", in_ready, 1);
    chk("post_reset_we", rf_we, 0);
    chk("post_reset_fwd", fwd_valid, 0);
    cycle();

    foreach (tv[i]) begin
      drive(1, tv[i].sel, tv[i].f3, tv[i].a, 1, tv[i].rd, tv[i].s0, tv[i].sk, 0, 0);
      cycle();
      idle();
      #1;
      chk($sformatf("vec%0d_we", i), rf_we, tv[i].ewe);
      chk($sformatf("vec%0d_data", i), rf_wdata, tv[i].edat);
      chk($sformatf("vec%0d_mis", i), ld_misalign, tv[i].emis);
      cycle();
    end
    #1;
    chk("mis_pulse_once", ld_misalign, 0);

    drive(1, 2, 0, 0, 1, 7, 0, 32'hDEAD_BEEF, 0, 0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #1;
      chk("stall_we", rf_we, 0);
      chk("stall_fwd_valid", fwd_valid, 1);
      chk("stall_fwd_data", fwd_data, 32'hDEAD_BEEF);
      cycle();
    end
    idle();
    #1;
    chk("stall_commit_we", rf_we, 1);
    chk("stall_commit_addr", rf_waddr, 7);
    cycle();
    #1;
    chk("stall_no_repeat", rf_we, 0);

    c0 = m_cnt;
    drive(1, 2, 0, 0, 1, 9, 0, 32'h5555_AAAA, 0, 1);
    cycle();
    idle();
    #1;
    chk("flush_drop_we", rf_we, 0);
    chk("flush_drop_fwd", fwd_valid, 0);
    cycle();
    drive(1, 2, 0, 0, 1, 9, 0, 32'h5555_AAAA, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cycle();
    idle();
    #1;
    chk("flush_stalled_we", rf_we, 0);
    chk("flush_stalled_fwd", fwd_valid, 0);
`ifdef WB_STAGE_RETIRE_CNT_EN
    chk("flush_cnt_same", retire_cnt, c0);
`endif
    cycle();

    drive(1, 2, 0, 0, 1, 0, 0, 32'h0BAD_F00D, 0, 0);
    cycle();
    idle();
    #1;
    chk("x0_we", rf_we, 0);
    chk("x0_fwd", fwd_valid, 0);
    cycle();

    drive(1, 2, 0, 0, 1, 12, 0, 32'h1357_9BDF, 0, 0);
    cycle();
    idle();
    rst = 1;
    #1;
    chk("rst_ready_low", in_ready, 0);
    cycle();
    rst = 0;
    #1;
    chk("rst_we", rf_we, 0);
    chk("rst_fwd", fwd_valid, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_ready_high", in_ready, 1);
    cycle();

    for (int i = 0; i < 500; i++) begin
      rst = $urandom_range(0, 59) == 0;
      in_valid = $urandom_range(0, 3) != 0;
      stall = $urandom_range(0, 3) == 0;
      flush = $urandom_range(0, 9) == 0;
      in_sel = 2'($urandom);
      in_ld_funct3 = 3'($urandom);
      in_addr_lo = 3'($urandom);
      in_we = 1'($urandom);
      in_rd = 5'($urandom);
      in_src = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    rst = 0;
    idle();
    cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
